// File: rtl/transpose_buffer.sv
// ----------------------------------------------------------------------------
// transpose_buffer
//
// Transpose memory between the first-stage scaling output and the second 1-D
// transform pass of the HEVC DCT/IDCT datapath. An NxN block (N = 4/8/16/32)
// is written one row per handshake, then read back one column per handshake,
// so the second pass sees the transposed block. Single buffer: a block is
// completely filled before it is drained; fill and drain never overlap.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset (state, counters, latched size)
//   size       block size code of the row presented: 0=4,1=8,2=16,3=32;
//              only sampled on the first row of a block
//   in_valid   din holds a valid row
//   in_ready   buffer accepts a row this cycle (high while filling)
//   din        row lanes 0..31, lane i at [i*WIDTH +: WIDTH], signed
//   out_valid  dout holds a valid column (high while draining)
//   out_ready  downstream accepts the column this cycle
//   dout       column lanes 0..31, same packing as din; lanes >= N are 0
//   out_last   high with the final column (index N-1) of the block
//   out_size   latched size code of the block being drained
// ----------------------------------------------------------------------------
module transpose_buffer #(
  parameter int unsigned WIDTH = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            size,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WIDTH-1:0]   din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WIDTH-1:0]   dout,
  output logic                  out_last,
  output logic [1:0]            out_size
);

  localparam int unsigned LANES = 32;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            row_cnt_q, row_cnt_d;
  logic [4:0]            col_cnt_q, col_cnt_d;
  logic [1:0]            size_q, size_d;
  logic [32*WIDTH-1:0]   hold_q;

  // Coefficient storage, mem_q[row][col]. Not reset: every lane that is ever
  // read back has been written earlier in the same block.
  logic [WIDTH-1:0]      mem_q [LANES][LANES];

  logic [1:0]            size_eff;
  logic [5:0]            n_wr;
  logic [5:0]            n_rd;
  logic                  row_last;
  logic                  col_last;
  logic                  wr_en;
  logic [32*WIDTH-1:0]   col_rd;

  // The first row of a block uses the incoming size in the same cycle it is
  // latched; later rows use the latched value so mid-block changes are inert.
  always_comb begin
    size_eff = (row_cnt_q == 5'd0) ? size : size_q;
    n_wr     = 6'd4 << size_eff;
    n_rd     = 6'd4 << size_q;
    row_last = (row_cnt_q == 5'(n_wr - 6'd1));
    col_last = (col_cnt_q == 5'(n_rd - 6'd1));
    wr_en    = (state_q == FILL) && in_valid;
  end

  // State, counters and latched size.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      size_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      size_q    <= size_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    size_d    = size_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (row_cnt_q == 5'd0) begin
            size_d = size;
          end
          if (row_last) begin
            row_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            row_cnt_d = row_cnt_q + 5'd1;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (col_last) begin
            col_cnt_d = '0;
            state_d   = FILL;
          end else begin
            col_cnt_d = col_cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Row write: only lanes below N are stored, the rest of din is dropped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned c = 0; c < LANES; c++) begin
        if (c < 32'(n_wr)) begin
          mem_q[row_cnt_q][c] <= din[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Column read: lane r of the output is row r of the stored block.
  always_comb begin
    col_rd = '0;
    for (int unsigned r = 0; r < LANES; r++) begin
      if (r < 32'(n_rd)) begin
        col_rd[r*WIDTH +: WIDTH] = mem_q[r][col_cnt_q];
      end
    end
  end

  // dout is a live read while draining; outside a drain it keeps showing the
  // last column presented (zero after reset), so a shadow copy is tracked.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (state_q == DRAIN) begin
      hold_q <= col_rd;
    end
  end

  always_comb begin
    dout     = (state_q == DRAIN) ? col_rd : hold_q;
    out_last = (state_q == DRAIN) && col_last;
    out_size = size_q;
  end

endmodule

// File: tb/tb_transpose_buffer.sv
module tb_transpose_buffer;

  localparam int unsigned W  = 22;
  localparam int unsigned DW = 32*W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    size;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          out_last;
  logic [1:0]    out_size;

  transpose_buffer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .size      (size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_last  (out_last),
    .out_size  (out_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    logic [1:0]    sz;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;
  int          mode = 0;          // 0: ready=1, 1: 1,0,0,1 pattern, 2: random, 3: manual
  int unsigned pat = 0;

  // Reference block: rows as presented, transposed with plain indexing.
  logic [W-1:0] ref_m [32][32];
  int unsigned  mrow = 0;
  int unsigned  mn   = 4;
  logic [1:0]   msz  = 2'd0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_row(input logic [1:0] sz, input logic [DW-1:0] d);
    exp_t e;
    if (mrow == 0) begin
      msz = sz;
      mn  = 4 << sz;
    end
    for (int unsigned c = 0; c < mn; c++) ref_m[mrow][c] = d[c*W +: W];
    mrow++;
    if (mrow == mn) begin
      for (int unsigned c = 0; c < mn; c++) begin
        e.d = '0;
        for (int unsigned r = 0; r < mn; r++) e.d[r*W +: W] = ref_m[r][c];
        e.last = (c == mn - 1);
        e.sz   = msz;
        exp_q.push_back(e);
      end
      mrow = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_row(input logic [1:0] sz, input logic [DW-1:0] d);
    bit done;
    done     = 1'b0;
    size     = sz;
    din      = d;
    in_valid = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL row_accept_timeout got=0 want=1");
    end else begin
      model_row(sz, d);
    end
  endtask

  task automatic wait_drain(input bit garbage);
    for (int k = 0; k < 600 && exp_q.size() != 0; k++) begin
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        din      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] d;
    for (int unsigned c = 0; c < 32; c++) d[c*W +: W] = W'($urandom);
    return d;
  endfunction

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
          pat++;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk_s("in_ready", 8'(in_ready), 8'(exp_q.size() == 0));
        chk_s("out_valid", 8'(out_valid), 8'(exp_q.size() != 0));
        if (out_valid === 1'b1 && exp_q.size() != 0) begin
          e = exp_q[0];
          chk("dout", dout, e.d);
          chk_s("out_last", 8'(out_last), 8'(e.last));
          chk_s("out_size", 8'(out_size), 8'(e.sz));
          if (out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    size      = 2'd0;
    in_valid  = 1'b0;
    din       = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_s("rst_in_ready", 8'(in_ready), 8'd1);
    chk_s("rst_out_valid", 8'(out_valid), 8'd0);
    chk_s("rst_out_last", 8'(out_last), 8'd0);
    chk_s("rst_out_size", 8'(out_size), 8'd0);
    chk("rst_dout", dout, '0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // 4x4 pattern, lane c of row r = 10r+c (upper lanes also nonzero)
    mode = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 32; c++) d[c*W +: W] = W'(10*r + c);
      send_row(2'd0, d);
    end
    wait_drain(1'b0);

    // 32x32 with a negative corner value
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) d[c*W +: W] = W'(r*32 + c);
      if (r == 31) d[31*W +: W] = '1;
      send_row(2'd3, d);
    end
    wait_drain(1'b0);

    // 8x8 under 1,0,0,1 backpressure, garbage in_valid pulses while draining
    mode = 1;
    pat  = 0;
    for (int r = 0; r < 8; r++) send_row(2'd1, rand_row());
    wait_drain(1'b1);
    mode = 0;

    // Size changes after row 0 are ignored
    send_row(2'd1, rand_row());
    for (int r = 1; r < 8; r++) send_row(2'd3, rand_row());
    wait_drain(1'b0);

    // Reset after 2 of 4 columns drained
    mode      = 3;
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) send_row(2'd0, rand_row());
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    mrow = 0;
    @(negedge clk);
    chk_s("drain_rst_out_valid", 8'(out_valid), 8'd0);
    chk_s("drain_rst_in_ready", 8'(in_ready), 8'd1);
    @(posedge clk); #1;
    mode = 0;
    for (int r = 0; r < 4; r++) send_row(2'd0, rand_row());
    wait_drain(1'b0);

    // Reset after 5 rows of a 16x16 block
    for (int r = 0; r < 5; r++) send_row(2'd2, rand_row());
    rst = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    mrow = 0;
    for (int r = 0; r < 16; r++) send_row(2'd2, rand_row());
    wait_drain(1'b0);

    // Random blocks, random sizes, random gaps and random out_ready
    mode = 2;
    for (int b = 0; b < 6; b++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      for (int unsigned r = 0; r < (4 << sz); r++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_row(sz, rand_row());
      end
      wait_drain(1'b0);
    end
    mode = 0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
